// File: rtl/kgp_multicycle_controller.sv
// kgp_multicycle_controller: multi-cycle control FSM for the KGP-RISC core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the
// ALU class code and the register-file, PC, IR and memory strobes. Every access
// on the unified memory port waits for mem_ready, with a timeout into ERROR.
// Optional build macro KGP_PERF_CNT_EN adds the cycle and retired-instruction
// counters. When it is undefined, both counter ports read zero.
module kgp_multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic [2:0]  aluop,
  output logic        alu_src_imm,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        busy,
  output logic        halted,
  output logic        error,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
  } state_t;

  localparam logic [5:0] OP_ARITH = 6'b000000;
  localparam logic [5:0] OP_LOGIC = 6'b000001;
  localparam logic [5:0] OP_SHIFT = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b000011;
  localparam logic [5:0] OP_LOAD  = 6'b000100;
  localparam logic [5:0] OP_STORE = 6'b000101;
  localparam logic [5:0] OP_BEQZ  = 6'b000110;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ARITH = 3'b000;
  localparam logic [2:0] ALU_LOGIC = 3'b001;
  localparam logic [2:0] ALU_SHIFT = 3'b010;
  localparam logic [2:0] ALU_NOP   = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b101;

  // The count value of the last allowed wait cycle. If mem_ready is still low
  // in that cycle, the access has timed out.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
  logic             wait_expired;

  assign wait_expired = (wait_cnt == WAIT_LAST);

  // State, latched opcode and memory wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every register then
      // samples pre-edge values, and the result does not depend on process order.
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  // Next-state and strobe decode from state, op_q and the memory handshake.
  always_comb begin
    // NOTE: every output gets a default before the case statement. A path that
    // does not mention a signal then cannot infer a latch.
    state_nx    = state;
    wait_cnt_nx = '0;
    aluop       = ALU_NOP;
    alu_src_imm = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end

      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end else if (wait_expired) begin
          state_nx = S_ERROR;
        end else begin
          wait_cnt_nx = wait_cnt + CNT_W'(1);
        end
      end

      S_DECODE: begin
        // op_q is loaded in this cycle, so branch on the live opcode field.
        case (opcode)
          OP_ARITH, OP_LOGIC, OP_SHIFT, OP_ADDI,
          OP_LOAD, OP_STORE, OP_BEQZ: state_nx = S_EXEC;
          OP_HALT:                    state_nx = S_HALT;
          default:                    state_nx = S_ERROR;
        endcase
      end

      S_EXEC: begin
        case (op_q)
          OP_ARITH: begin aluop = ALU_ARITH; state_nx = S_WB; end
          OP_LOGIC: begin aluop = ALU_LOGIC; state_nx = S_WB; end
          OP_SHIFT: begin aluop = ALU_SHIFT; state_nx = S_WB; end
          OP_ADDI: begin
            aluop       = ALU_ADD;
            alu_src_imm = 1'b1;
            state_nx    = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            aluop       = ALU_ADD;
            alu_src_imm = 1'b1;
            state_nx    = S_MEM;
          end
          OP_BEQZ: begin
            aluop    = ALU_SUB;
            pc_write = zero_flag;
            pc_src   = zero_flag;
            state_nx = S_FETCH;
          end
          default: state_nx = S_ERROR;
        endcase
      end

      S_MEM: begin
        // Keep the address computation stable for the whole access.
        aluop       = ALU_ADD;
        alu_src_imm = 1'b1;
        if (op_q == OP_STORE) mem_write = 1'b1;
        else                  mem_read  = 1'b1;
        if (mem_ready) begin
          state_nx = (op_q == OP_STORE) ? S_FETCH : S_WB;
        end else if (wait_expired) begin
          state_nx = S_ERROR;
        end else begin
          wait_cnt_nx = wait_cnt + CNT_W'(1);
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        state_nx   = S_FETCH;
      end

      S_HALT, S_ERROR: state_nx = state;

      default: state_nx = S_IDLE;
    endcase
  end

  assign busy   = (state inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB});
  assign halted = (state == S_HALT);
  assign error  = (state == S_ERROR);

`ifdef KGP_PERF_CNT_EN
  logic retire;

  // An instruction retires when control returns to FETCH from an execute-side state.
  assign retire = (state inside {S_EXEC, S_MEM, S_WB}) && (state_nx == S_FETCH);

  // Free-running performance counters. They wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (busy)   cycle_count <= cycle_count + 32'd1;
      if (retire) instr_count <= instr_count + 32'd1;
    end
  end
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_kgp_multicycle_controller.sv
// Directed self-checking bench for kgp_multicycle_controller (TIMEOUT=16).
// Expected strobe vectors are queued when a cycle's stimulus is driven. They are
// popped and compared once the DUT's combinational outputs have settled.
module tb_kgp_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  opcode = '0;
  logic        zero_flag = 1'b0;
  logic        mem_ready = 1'b0;
  logic [2:0]  aluop;
  logic        alu_src_imm, mem_read, mem_write, ir_write, pc_write, pc_src;
  logic        reg_write, mem_to_reg, busy, halted, error;
  logic [31:0] cycle_count, instr_count;

  kgp_multicycle_controller #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .aluop(aluop),
    .alu_src_imm(alu_src_imm), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .busy(busy),
    .halted(halted), .error(error), .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

`ifdef KGP_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Vector layout: {busy,halted,error, aluop[2:0], imm,mr,mw,irw,pcw,pcs,rw,m2r}
  localparam logic [13:0] X_IDLE    = {3'b000, 3'b011, 8'b0000_0000};
  localparam logic [13:0] X_FETCH_R = {3'b100, 3'b011, 8'b0101_1000};
  localparam logic [13:0] X_FETCH_W = {3'b100, 3'b011, 8'b0100_0000};
  localparam logic [13:0] X_DEC     = {3'b100, 3'b011, 8'b0000_0000};
  localparam logic [13:0] X_EX_AR   = {3'b100, 3'b000, 8'b0000_0000};
  localparam logic [13:0] X_EX_LG   = {3'b100, 3'b001, 8'b0000_0000};
  localparam logic [13:0] X_EX_IMM  = {3'b100, 3'b100, 8'b1000_0000};
  localparam logic [13:0] X_MEM_LD  = {3'b100, 3'b100, 8'b1100_0000};
  localparam logic [13:0] X_MEM_ST  = {3'b100, 3'b100, 8'b1010_0000};
  localparam logic [13:0] X_WB      = {3'b100, 3'b011, 8'b0000_0010};
  localparam logic [13:0] X_WB_LD   = {3'b100, 3'b011, 8'b0000_0011};
  localparam logic [13:0] X_BR_T    = {3'b100, 3'b101, 8'b0000_1100};
  localparam logic [13:0] X_BR_N    = {3'b100, 3'b101, 8'b0000_0000};
  localparam logic [13:0] X_HALT    = {3'b010, 3'b011, 8'b0000_0000};
  localparam logic [13:0] X_ERR     = {3'b001, 3'b011, 8'b0000_0000};

  typedef struct {
    string       tag;
    logic [13:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] m_cycles = '0;
  logic [31:0] m_instr  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [13:0] obs_vec();
    return {busy, halted, error, aluop, alu_src_imm, mem_read, mem_write,
            ir_write, pc_write, pc_src, reg_write, mem_to_reg};
  endfunction

  // Pop the oldest expectation and compare it with the settled outputs.
  task automatic compare_front();
    sb_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, 32'(obs_vec()), 32'(e.exp));
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cyc"}, cycle_count, PERF ? m_cycles : 32'd0);
    check({tag, "_ins"}, instr_count, PERF ? m_instr  : 32'd0);
  endtask

  // One clock cycle. Drive the inputs at the falling edge, queue the expectation,
  // then compare. Afterwards, advance the counter model for the coming rising edge.
  task automatic step(input string tag, input logic st, input logic [5:0] opc,
                      input logic zf, input logic rdy, input logic [13:0] exp,
                      input logic retire);
    @(negedge clk);
    start = st; opcode = opc; zero_flag = zf; mem_ready = rdy;
    sb_q.push_back('{tag, exp});
    #1;
    compare_front();
    check_counters(tag);
    if (exp[13]) m_cycles++;
    if (retire)  m_instr++;
  endtask

  // Assert reset asynchronously, check the idle state, then release it.
  task automatic apply_reset(input string tag);
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; zero_flag = 1'b0;
    #1;
    m_cycles = '0;
    m_instr  = '0;
    sb_q.push_back('{tag, X_IDLE});
    compare_front();
    check_counters(tag);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    apply_reset("reset");

    // R-arith with memory always ready: four cycles per instruction.
    step("idle_start", 1, 6'b000000, 0, 1, X_IDLE,    0);
    step("ar_fetch",   0, 6'b000000, 0, 1, X_FETCH_R, 0);
    step("ar_dec",     0, 6'b000000, 0, 1, X_DEC,     0);
    step("ar_exec",    1, 6'b000000, 0, 1, X_EX_AR,   0);
    step("ar_wb",      0, 6'b000000, 0, 1, X_WB,      1);

    // Logic operation.
    step("lg_fetch",   0, 6'b000001, 0, 1, X_FETCH_R, 0);
    step("lg_dec",     0, 6'b000001, 0, 1, X_DEC,     0);
    step("lg_exec",    0, 6'b000001, 0, 1, X_EX_LG,   0);
    step("lg_wb",      0, 6'b000001, 0, 1, X_WB,      1);

    // Load with three wait cycles in MEM.
    step("ld_fetch",   0, 6'b000100, 0, 1, X_FETCH_R, 0);
    step("ld_dec",     0, 6'b000100, 0, 1, X_DEC,     0);
    step("ld_exec",    0, 6'b000100, 0, 0, X_EX_IMM,  0);
    for (int i = 0; i < 3; i++)
      step("ld_mem_wait", 0, 6'b000100, 0, 0, X_MEM_LD, 0);
    step("ld_mem_done", 0, 6'b000100, 0, 1, X_MEM_LD, 0);
    step("ld_wb",      0, 6'b000100, 0, 1, X_WB_LD,   1);

    // Branch taken, then not taken.
    step("bt_fetch",   0, 6'b000110, 0, 1, X_FETCH_R, 0);
    step("bt_dec",     0, 6'b000110, 0, 1, X_DEC,     0);
    step("bt_exec",    0, 6'b000110, 1, 1, X_BR_T,    1);
    step("bn_fetch",   0, 6'b000110, 0, 1, X_FETCH_R, 0);
    step("bn_dec",     0, 6'b000110, 0, 1, X_DEC,     0);
    step("bn_exec",    0, 6'b000110, 0, 1, X_BR_N,    1);

    // mem_ready arrives on the 16th FETCH cycle: it wins over the timeout.
    for (int i = 0; i < 15; i++)
      step("to_wait", 0, 6'b000011, 0, 0, X_FETCH_W, 0);
    step("to_last_ready", 0, 6'b000011, 0, 1, X_FETCH_R, 0);
    step("ai_dec",     0, 6'b000011, 0, 1, X_DEC,     0);
    step("ai_exec",    0, 6'b000011, 0, 1, X_EX_IMM,  0);
    step("ai_wb",      0, 6'b000011, 0, 1, X_WB,      1);

    // Store, with reset asserted in the middle of the MEM cycle.
    step("st_fetch",   0, 6'b000101, 0, 1, X_FETCH_R, 0);
    step("st_dec",     0, 6'b000101, 0, 1, X_DEC,     0);
    step("st_exec",    0, 6'b000101, 0, 0, X_EX_IMM,  0);
    step("st_mem",     0, 6'b000101, 0, 0, X_MEM_ST,  0);
    apply_reset("st_mid_reset");

    // FETCH timeout: 16 wait cycles, then ERROR, which ignores start and ready.
    step("e_start",    1, 6'b000000, 0, 0, X_IDLE,    0);
    for (int i = 0; i < 16; i++)
      step("e_wait", 0, 6'b000000, 0, 0, X_FETCH_W, 0);
    step("e_error",    1, 6'b000000, 0, 1, X_ERR,     0);
    step("e_sticky",   1, 6'b000000, 0, 1, X_ERR,     0);
    apply_reset("e_reset");

    // Illegal opcode goes to ERROR.
    step("il_start",   1, 6'b001010, 0, 1, X_IDLE,    0);
    step("il_fetch",   0, 6'b001010, 0, 1, X_FETCH_R, 0);
    step("il_dec",     0, 6'b001010, 0, 1, X_DEC,     0);
    step("il_error",   0, 6'b001010, 0, 1, X_ERR,     0);
    apply_reset("il_reset");

    // Halt: terminal, not busy, start pulses ignored.
    step("h_start",    1, 6'b111111, 0, 1, X_IDLE,    0);
    step("h_fetch",    0, 6'b111111, 0, 1, X_FETCH_R, 0);
    step("h_dec",      0, 6'b111111, 0, 1, X_DEC,     0);
    step("h_halt",     1, 6'b111111, 0, 1, X_HALT,    0);
    step("h_halt_st0", 0, 6'b111111, 0, 1, X_HALT,    0);
    step("h_halt_st1", 1, 6'b000000, 0, 1, X_HALT,    0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/kgp_multicycle_controller.md
Name: kgp_multicycle_controller

Overview:
- Multi-cycle control FSM for the KGP-RISC core. Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the 3-bit aluop consumed by the ALU control unit, plus register-file, PC, IR and memory strobes.
- Sits between the instruction register opcode field and the shared unified memory port. Handles a ready handshake with timeout.

Parameters:
- TIMEOUT, 16, number of consecutive wait cycles without mem_ready before entering ERROR (range 1..255).
- CNT_W, 8, width of the internal wait counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  leave IDLE and begin fetching.
- opcode  input  6  IR opcode field, valid from the DECODE cycle onward.
- zero_flag  input  1  ALU zero result, sampled in EXEC for branches.
- mem_ready  input  1  memory completes the current read/write this cycle.
- aluop  output  3  ALU control class: 000 arith, 001 logic, 010 shift, 100 add, 101 sub, 011 no-op.
- alu_src_imm  output  1  ALU operand B from the immediate.
- mem_read  output  1  memory read request (fetch or load).
- mem_write  output  1  memory write request (store).
- ir_write  output  1  load IR from memory data.
- pc_write  output  1  update PC.
- pc_src  output  1  0: PC+4, 1: branch target.
- reg_write  output  1  register file write enable.
- mem_to_reg  output  1  writeback data from memory.
- busy  output  1  high in FETCH, DECODE, EXEC, MEM, WB.
- halted  output  1  high in HALT.
- error  output  1  high in ERROR.
- cycle_count  output  32  performance counter (see Optional Feature).
- instr_count  output  32  retired instructions (see Optional Feature).

Behaviour:
- Reset (async): state IDLE, op_q=0, wait counter=0. All strobes 0, aluop=011.
- Outputs are decoded from state and op_q. ir_write/pc_write in FETCH and load/store completion depend on mem_ready in the same cycle.
- Opcode map for op_q:
  - 000000 R-arith, 000001 logic, 000010 shift, 000011 add-immediate
  - 000100 load, 000101 store, 000110 branch-if-zero, 111111 halt
  - anything else is illegal.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH: mem_read=1.
  - mem_ready=1 -> ir_write=1, pc_write=1, pc_src=0; next DECODE.
  - Otherwise the wait counter increments.
- DECODE: op_q <= opcode.
  - Illegal opcode -> ERROR.
  - Halt -> HALT.
  - Any other opcode -> EXEC.
- EXEC: aluop driven from op_q.
  - R-arith 000, logic 001, shift 010; each -> WB.
  - Add-immediate, load, store: aluop=100, alu_src_imm=1. Add-immediate -> WB; load/store -> MEM.
  - Branch: aluop=101. If zero_flag=1, pc_write=1 and pc_src=1. Next FETCH.
- MEM: aluop=100, alu_src_imm=1 held stable.
  - Load: mem_read=1. Store: mem_write=1.
  - On mem_ready: load -> WB, store -> FETCH.
  - Otherwise the wait counter increments.
- WB: reg_write=1 for one cycle; mem_to_reg=1 only for load. Next FETCH.
- Wait counter:
  - Clears on entry to FETCH/MEM and on mem_ready.
  - If it reaches TIMEOUT with mem_ready still 0, the next state is ERROR.
  - If mem_ready=1 arrives in the same cycle the counter reaches TIMEOUT, mem_ready wins.
- HALT and ERROR are terminal, exited only by rst. All strobes are 0 and aluop=011 in both. start is ignored.
- start is ignored outside IDLE.
- Strobes are never asserted in IDLE, HALT or ERROR.
- mem_read and mem_write are never both high.
- rst mid-instruction: immediate return to IDLE. No strobe survives the reset edge.

Optional Feature:
- Macro KGP_PERF_CNT_EN.
- Defined:
  - cycle_count increments on every clock with busy=1.
  - instr_count increments on each transition into FETCH from EXEC, MEM or WB.
  - Both clear on rst and wrap at 2^32.
- Undefined: both ports are tied to 0 and no counter flops are built. FSM behaviour is identical.

Test Plan:
- Reset, then start=1, mem_ready=1 always, opcode=000000:
  - FETCH, DECODE, EXEC (aluop=000), WB (reg_write=1), then FETCH.
  - 4 cycles per instruction; instr_count=1 after the first retire (with KGP_PERF_CNT_EN).
- Load, opcode=000100, mem_ready low 3 cycles in MEM:
  - mem_read held 4 cycles.
  - Then WB with reg_write=1 and mem_to_reg=1; aluop=100 throughout EXEC/MEM.
- Branch, opcode=000110:
  - zero_flag=1: EXEC asserts pc_write=1, pc_src=1.
  - zero_flag=0: pc_write=0.
  - Next state FETCH in both cases.
- mem_ready held 0 in FETCH, TIMEOUT=16: after 16 wait cycles error=1 and all strobes are 0. Repeat with mem_ready=1 on the 16th cycle: proceeds to DECODE with no error.
- Illegal opcode 001010 leads to error=1. Opcode 111111 leads to halted=1 and busy=0, with start pulses ignored.
- Assert rst during MEM of a store (mem_write=1): same-cycle async drop to IDLE. mem_write=0, aluop=011 and counters zeroed.
